// File: rtl/elvm_cpu_pkg.sv
// Shared definitions for the ELVM-style CPU: widths, instruction field layout,
// opcode and register index constants, fetch FSM state and decoded word type.
package elvm_cpu_pkg;

  // Address and word geometry
  localparam int ADDR_W = 8;
  localparam int INSN_W = 37;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  // Instruction field layout: {imm_sel, opcode, dst, src, rsvd, imm}
  localparam int IMM_SEL_BIT = 36;
  localparam int OPC_HI      = 35;
  localparam int OPC_LO      = 31;
  localparam int DST_HI      = 30;
  localparam int DST_LO      = 28;
  localparam int SRC_HI      = 27;
  localparam int SRC_LO      = 25;
  localparam int RSVD_BIT    = 24;
  localparam int IMM_HI      = 23;
  localparam int IMM_LO      = 0;

  localparam int OPC_W = OPC_HI - OPC_LO + 1;
  localparam int REG_W = DST_HI - DST_LO + 1;
  localparam int IMM_W = IMM_HI - IMM_LO + 1;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_PUTC = 5'b00101;
  localparam logic [OPC_W-1:0] OP_EXIT = 5'b00111;

  // Register indices
  localparam logic [REG_W-1:0] REG_A  = 3'd0;
  localparam logic [REG_W-1:0] REG_B  = 3'd1;
  localparam logic [REG_W-1:0] REG_C  = 3'd2;
  localparam logic [REG_W-1:0] REG_D  = 3'd3;
  localparam logic [REG_W-1:0] REG_BP = 3'd4;
  localparam logic [REG_W-1:0] REG_SP = 3'd5;

  // Fetch FSM
  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_t;

  // Decoded instruction fields
  typedef struct packed {
    logic             imm_sel;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src;
    logic [IMM_W-1:0] imm;
  } insn_t;

endpackage

// File: rtl/insn_unpack.sv
// Splits a raw instruction word into its decoded fields.
// Purely combinational, zero latency; the reserved bit is dropped.
module insn_unpack
  import elvm_cpu_pkg::*;
(
  input  logic [INSN_W-1:0] i_word,
  output insn_t             o_insn
);

  logic w_unused_rsvd;

  // Field extraction by fixed bit positions
  always_comb begin
    o_insn         = '0;
    o_insn.imm_sel = i_word[IMM_SEL_BIT];
    o_insn.opcode  = i_word[OPC_HI:OPC_LO];
    o_insn.dst     = i_word[DST_HI:DST_LO];
    o_insn.src     = i_word[SRC_HI:SRC_LO];
    o_insn.imm     = i_word[IMM_HI:IMM_LO];
  end

  // Reserved bit carries no meaning today
  assign w_unused_rsvd = i_word[RSVD_BIT];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the ROM address, registers the decoded word.
// Latency: word presented one cycle after its address is driven; 1 insn/cycle.
// Backpressure: out_valid & !out_ready holds PC and output register stable.
module instr_fetch
  import elvm_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INSN_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_imm_sel,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [REG_W-1:0]  out_dst,
  output logic [REG_W-1:0]  out_src,
  output logic [IMM_W-1:0]  out_imm,
  output logic              halted,
  output logic [31:0]       insn_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_pc;
  insn_t             r_out;
  logic [31:0]       r_insn_count;

  insn_t             w_insn;
  logic              w_can_load;
  logic              w_load;
  logic              w_accept;
  logic              w_is_exit;

  insn_unpack u_unpack (
    .i_word (rom_data),
    .o_insn (w_insn)
  );

  // Output register is free when empty or being drained this cycle
  assign w_can_load = !r_out_valid || out_ready;
  // Redirect outranks a capture; nothing is fetched while halted
  assign w_load     = (r_state == S_RUN) && !redirect_valid && w_can_load;
  assign w_accept   = r_out_valid && out_ready;
  assign w_is_exit  = (w_insn.opcode == OP_EXIT);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: redirect always resumes, capturing EXIT stops fetch
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid)            w_state_nxt = S_RUN;
    else if (w_load && w_is_exit)  w_state_nxt = S_HALT;
  end

  // FSM outputs
  always_comb begin
    halted = (r_state == S_HALT);
  end

  // Program counter: redirect target, else advance on each capture (wraps)
  always_ff @(posedge clk) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= redirect_pc;
    else if (w_load)         r_pc <= r_pc + 1'b1;
  end

  // Output register: flushed by redirect, filled on capture, drained on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out       <= '0;
    end else if (redirect_valid) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= r_pc;
      r_out       <= w_insn;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accepted-handshake counter, counts even when a redirect lands alongside
  always_ff @(posedge clk) begin
    if (rst)           r_insn_count <= '0;
    else if (w_accept) r_insn_count <= r_insn_count + 32'd1;
  end

  assign rom_addr    = r_pc;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_imm_sel = r_out.imm_sel;
  assign out_opcode  = r_out.opcode;
  assign out_dst     = r_out.dst;
  assign out_src     = r_out.src;
  assign out_imm     = r_out.imm;
  assign insn_count  = r_insn_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a behavioural combinational ROM.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [36:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic        out_imm_sel;
  logic [4:0]  out_opcode;
  logic [2:0]  out_dst;
  logic [2:0]  out_src;
  logic [23:0] out_imm;
  logic        halted;
  logic [31:0] insn_count;

  logic [36:0] rom [256];
  int tests_run;
  int tests_failed;

  assign rom_data = rom[rom_addr];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_imm_sel    (out_imm_sel),
    .out_opcode     (out_opcode),
    .out_dst        (out_dst),
    .out_src        (out_src),
    .out_imm        (out_imm),
    .halted         (halted),
    .insn_count     (insn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] mkw(input logic sel, input logic [4:0] opc,
                                      input logic [2:0] dst, input logic [2:0] src,
                                      input logic [23:0] imm);
    return {sel, opc, dst, src, 1'b0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every address holds a non-EXIT ADD whose immediate equals its address
  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = mkw(1'b0, 5'b00001, 3'd1, 3'd2, {16'h0, 8'(i)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom();
    out_ready = 1'b0;
    do_reset();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests_run++; if (rom_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_pc got %h exp 00", rom_addr); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got %b exp 0", halted); end
    tests_run++; if (insn_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", insn_count); end
    tests_run++; if ({out_pc, out_imm_sel, out_opcode, out_dst, out_src, out_imm} !== 44'h0)
      begin tests_failed++; $display("FAIL reset_fields got %h/%h/%h exp 0", out_pc, out_opcode, out_imm); end
  endtask

  task automatic test_sequence();
    logic [7:0]  e_pc  [3];
    logic [4:0]  e_opc [3];
    logic [23:0] e_imm [3];
    logic        e_sel [3];
    e_pc  = '{8'h00, 8'h01, 8'h02};
    e_opc = '{5'b00001, 5'b00001, 5'b00101};
    e_imm = '{24'h41, 24'h01, 24'h00};
    e_sel = '{1'b1, 1'b1, 1'b0};
    fill_rom();
    rom[0] = mkw(1'b1, 5'b00001, 3'd0, 3'd0, 24'h41);
    rom[1] = mkw(1'b1, 5'b00001, 3'd0, 3'd0, 24'h01);
    rom[2] = mkw(1'b0, 5'b00101, 3'd2, 3'd1, 24'h00);
    out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_pc !== e_pc[k])
        begin tests_failed++; $display("FAIL seq_pc[%0d] got v=%b pc=%h exp v=1 pc=%h", k, out_valid, out_pc, e_pc[k]); end
      tests_run++; if (out_opcode !== e_opc[k] || out_imm !== e_imm[k] || out_imm_sel !== e_sel[k])
        begin tests_failed++; $display("FAIL seq_fields[%0d] got %b/%h/%b exp %b/%h/%b", k, out_opcode, out_imm, out_imm_sel, e_opc[k], e_imm[k], e_sel[k]); end
    end
    tests_run++; if (out_dst !== 3'd2 || out_src !== 3'd1)
      begin tests_failed++; $display("FAIL seq_regs got dst=%0d src=%0d exp dst=2 src=1", out_dst, out_src); end
    tick();
    tests_run++; if (insn_count !== 32'd3) begin tests_failed++; $display("FAIL seq_count got %0d exp 3", insn_count); end
    tests_run++; if (out_pc !== 8'h03) begin tests_failed++; $display("FAIL seq_next_pc got %h exp 03", out_pc); end
  endtask

  task automatic test_stall();
    fill_rom();
    rom[0] = mkw(1'b1, 5'b00001, 3'd0, 3'd0, 24'h41);
    out_ready = 1'b1;
    do_reset();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_imm !== 24'h41 || rom_addr !== 8'h01)
        begin tests_failed++; $display("FAIL stall_hold[%0d] got v=%b pc=%h imm=%h addr=%h exp 1/00/41/01", k, out_valid, out_pc, out_imm, rom_addr); end
    end
    out_ready = 1'b1;
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 8'h01 || out_imm !== 24'h01)
      begin tests_failed++; $display("FAIL stall_release got pc=%h imm=%h exp 01/01", out_pc, out_imm); end
    tick();
    tests_run++; if (out_pc !== 8'h02 || insn_count !== 32'd2)
      begin tests_failed++; $display("FAIL stall_next got pc=%h cnt=%0d exp 02/2", out_pc, insn_count); end
  endtask

  task automatic test_halt();
    fill_rom();
    rom[5] = mkw(1'b0, 5'b00111, 3'd0, 3'd0, 24'h05);
    out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 8'h05 || out_opcode !== 5'b00111 || halted !== 1'b1)
      begin tests_failed++; $display("FAIL halt_exit got v=%b pc=%h opc=%b h=%b exp 1/05/00111/1", out_valid, out_pc, out_opcode, halted); end
    tests_run++; if (rom_addr !== 8'h06) begin tests_failed++; $display("FAIL halt_addr got %h exp 06", rom_addr); end
    tick();
    tests_run++; if (out_valid !== 1'b0 || halted !== 1'b1)
      begin tests_failed++; $display("FAIL halt_drain got v=%b h=%b exp 0/1", out_valid, halted); end
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++; if (out_valid !== 1'b0 || rom_addr !== 8'h06 || out_pc !== 8'h05)
        begin tests_failed++; $display("FAIL halt_idle[%0d] got v=%b addr=%h pc=%h exp 0/06/05", k, out_valid, rom_addr, out_pc); end
    end
    tests_run++; if (insn_count !== 32'd6) begin tests_failed++; $display("FAIL halt_count got %0d exp 6", insn_count); end
    rst = 1'b1;
    tick();
    tests_run++; if (halted !== 1'b0 || rom_addr !== 8'h00 || insn_count !== 32'd0)
      begin tests_failed++; $display("FAIL halt_reset got h=%b addr=%h cnt=%0d exp 0/00/0", halted, rom_addr, insn_count); end
    rst = 1'b0;
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 8'h00)
      begin tests_failed++; $display("FAIL halt_restart got v=%b pc=%h exp 1/00", out_valid, out_pc); end
  endtask

  task automatic test_redirect();
    fill_rom();
    rom[3] = mkw(1'b0, 5'b00111, 3'd0, 3'd0, 24'h03);
    out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    tests_run++; if (out_pc !== 8'h03 || halted !== 1'b1)
      begin tests_failed++; $display("FAIL redir_exit got pc=%h h=%b exp 03/1", out_pc, halted); end
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    tick();
    redirect_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || halted !== 1'b0 || rom_addr !== 8'h80)
      begin tests_failed++; $display("FAIL redir_flush got v=%b h=%b addr=%h exp 0/0/80", out_valid, halted, rom_addr); end
    tests_run++; if (insn_count !== 32'd4) begin tests_failed++; $display("FAIL redir_count got %0d exp 4", insn_count); end
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 8'h80 || out_imm !== 24'h80)
      begin tests_failed++; $display("FAIL redir_target got v=%b pc=%h imm=%h exp 1/80/80", out_valid, out_pc, out_imm); end
  endtask

  task automatic test_wrap();
    logic [7:0] e_pc [3];
    e_pc = '{8'hFE, 8'hFF, 8'h00};
    fill_rom();
    out_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || rom_addr !== 8'hFE)
      begin tests_failed++; $display("FAIL wrap_redir got v=%b addr=%h exp 0/FE", out_valid, rom_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_pc !== e_pc[k] || out_imm !== {16'h0, e_pc[k]})
        begin tests_failed++; $display("FAIL wrap_pc[%0d] got pc=%h imm=%h exp %h", k, out_pc, out_imm, e_pc[k]); end
    end
    tests_run++; if (rom_addr !== 8'h01) begin tests_failed++; $display("FAIL wrap_addr got %h exp 01", rom_addr); end
  endtask

  task automatic test_reset_stall();
    fill_rom();
    out_ready = 1'b1;
    do_reset();
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    tests_run++; if (out_valid !== 1'b1 || insn_count !== 32'd1)
      begin tests_failed++; $display("FAIL rststall_pre got v=%b cnt=%0d exp 1/1", out_valid, insn_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0 || rom_addr !== 8'h00 || insn_count !== 32'd0 || halted !== 1'b0)
      begin tests_failed++; $display("FAIL rststall got v=%b addr=%h cnt=%0d h=%b exp 0/00/0/0", out_valid, rom_addr, insn_count, halted); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    test_reset();
    test_sequence();
    test_stall();
    test_halt();
    test_redirect();
    test_wrap();
    test_reset_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
